// File: rtl/alu_operand_2_decoder_if.sv
// alu_operand_2_decoder_if: fetch-side and ALU-side signals of the operand-2 decoder; ALU_OP2_DEC_STATS_EN adds counters
interface alu_operand_2_decoder_if #(
  parameter int DATA_W = 16,
  parameter int REG_ADDR_W = 3
);
  logic [15:0] in_instr;
  logic in_instr_valid;
  logic out_instr_ready;
  logic in_flush;
  logic out_valid;
  logic in_ready;
  logic [3:0] out_opcode;
  logic [REG_ADDR_W-1:0] out_rd_addr;
  logic [REG_ADDR_W-1:0] out_rs1_addr;
  logic [REG_ADDR_W-1:0] out_reg_addr_operand_2;
  logic [DATA_W-1:0] out_immediate_operand_2;
  logic out_sel_operand_2;
`ifdef ALU_OP2_DEC_STATS_EN
  logic [15:0] out_instr_count;
  logic [15:0] out_imm_count;
`endif
  modport slave (
    input in_instr, in_instr_valid, in_flush, in_ready,
    output out_instr_ready, out_valid, out_opcode, out_rd_addr, out_rs1_addr,
    output out_reg_addr_operand_2, out_immediate_operand_2, out_sel_operand_2
`ifdef ALU_OP2_DEC_STATS_EN
    , output out_instr_count, out_imm_count
`endif
  );
  modport master (
    output in_instr, in_instr_valid, in_flush, in_ready,
    input out_instr_ready, out_valid, out_opcode, out_rd_addr, out_rs1_addr,
    input out_reg_addr_operand_2, out_immediate_operand_2, out_sel_operand_2
`ifdef ALU_OP2_DEC_STATS_EN
    , input out_instr_count, out_imm_count
`endif
  );
endinterface

// File: rtl/alu_operand_2_decoder.sv
// alu_operand_2_decoder: registered operand-2 decode stage with 2-entry skid; ALU_OP2_DEC_STATS_EN adds accept counters
module alu_operand_2_decoder #(
  parameter int DATA_W = 16,
  parameter int IMM_W = 6,
  parameter int REG_ADDR_W = 3
) (
  input logic in_clk,
  input logic in_rst_n,
  alu_operand_2_decoder_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [3:0] opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] r2;
    logic [DATA_W-1:0] imm;
    logic sel;
  } dec_t;
  state_t state;
  dec_t dec, main_q, skid_q;
  logic valid_q, ready_q, acc, xfer;
  assign acc = bus.in_instr_valid & ready_q;
  assign xfer = valid_q & bus.in_ready;
  // decode the incoming word; opcode 4'b1111 is the only zero-extending I-type
  always_comb begin
    dec.opcode = bus.in_instr[15:12];
    dec.rd = bus.in_instr[9 +: REG_ADDR_W];
    dec.rs1 = bus.in_instr[6 +: REG_ADDR_W];
    dec.sel = bus.in_instr[15];
    dec.r2 = dec.sel ? '0 : bus.in_instr[3 +: REG_ADDR_W];
    dec.imm = dec.sel ? {{(DATA_W-IMM_W){bus.in_instr[IMM_W-1] & ~&bus.in_instr[15:12]}}, bus.in_instr[IMM_W-1:0]} : '0;
  end
  // main/skid occupancy FSM; ready is registered so fetch never sees downstream ready combinationally
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.in_flush) begin
      state <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          main_q <= dec;
          state <= ONE;
          valid_q <= 1'b1;
        end
        ONE: if (acc && xfer) main_q <= dec;
        else if (acc) begin
          skid_q <= dec;
          state <= FULL;
          ready_q <= 1'b0;
        end else if (xfer) begin
          state <= EMPTY;
          valid_q <= 1'b0;
        end
        FULL: if (xfer) begin
          main_q <= skid_q;
          state <= ONE;
          ready_q <= 1'b1;
        end
        default: state <= EMPTY;
      endcase
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_instr_ready = ready_q;
  assign bus.out_opcode = main_q.opcode;
  assign bus.out_rd_addr = main_q.rd;
  assign bus.out_rs1_addr = main_q.rs1;
  assign bus.out_reg_addr_operand_2 = main_q.r2;
  assign bus.out_immediate_operand_2 = main_q.imm;
  assign bus.out_sel_operand_2 = main_q.sel;
`ifdef ALU_OP2_DEC_STATS_EN
  logic [15:0] instr_count, imm_count;
  // saturating counts of accepted instructions; flush-cycle accepts are discarded and not counted
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      instr_count <= '0;
      imm_count <= '0;
    end else if (acc && !bus.in_flush) begin
      instr_count <= instr_count + 16'(~&instr_count);
      imm_count <= imm_count + 16'(dec.sel & ~&imm_count);
    end
  end
  assign bus.out_instr_count = instr_count;
  assign bus.out_imm_count = imm_count;
`endif
endmodule
